// File: rtl/bist_sig_compactor.sv
// Response-side BIST signature compactor: a MISR over a 3-bit response word, plus a golden compare at end of test.
// Optional BIST_SIG_XMASK_EN adds an e_mask input that zeroes selected response bits before compaction.
module bist_sig_compactor #(
  parameter int              W          = 8,
  parameter logic [W-1:0]    POLY       = 8'h1D,
  parameter logic [W-1:0]    SEED       = '0,
  parameter logic [W-1:0]    GOLDEN     = 8'hE2,
  parameter int              EXP_CYCLES = 9,
  parameter int              CW         = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          capture_en,
  input  logic          finish,
  input  logic [2:0]    e_in,
`ifdef BIST_SIG_XMASK_EN
  input  logic [2:0]    e_mask,
`endif
  output logic [W-1:0]  hf,
  output logic [CW-1:0] cycles,
  output logic          busy,
  output logic          sig_valid,
  output logic          pass_fail
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPACT = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CW-1:0] EXP_CW = CW'(EXP_CYCLES);

  logic [1:0]    state;
  logic [2:0]    e_eff;
  logic [W-1:0]  hf_shift;
  logic [W-1:0]  hf_next;
  logic [CW-1:0] cycles_inc;
  logic          compact;
  logic          count_ok;

`ifdef BIST_SIG_XMASK_EN
  assign e_eff = e_in & ~e_mask;
`else
  assign e_eff = e_in;
`endif

  // Galois left shift, response word folded into the low three bits
  always_comb begin
    hf_shift = {hf[W-2:0], 1'b0} ^ (hf[W-1] ? POLY : '0);
    hf_next  = hf_shift ^ {{(W-3){1'b0}}, e_eff};
  end

  assign cycles_inc = (&cycles) ? cycles : cycles + CW'(1);
  assign compact    = (state == COMPACT) && capture_en;
  assign count_ok   = (EXP_CYCLES == 0) || (cycles == EXP_CW);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      hf        <= SEED;
      cycles    <= '0;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
      pass_fail <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= COMPACT;
            hf     <= SEED;
            cycles <= '0;
            busy   <= 1'b1;
          end
        end
        COMPACT: begin
          if (compact) begin
            hf     <= hf_next;
            cycles <= cycles_inc;
          end
          if (finish) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          pass_fail <= (hf == GOLDEN) && count_ok;
          sig_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          // restart discards the previous verdict before the new session begins
          if (start) begin
            state     <= COMPACT;
            hf        <= SEED;
            cycles    <= '0;
            busy      <= 1'b1;
            sig_valid <= 1'b0;
            pass_fail <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          sig_valid <= 1'b0;
          pass_fail <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sig_compactor.sv
// Directed self-checking bench for bist_sig_compactor, with extra instances for the count-check and saturation cases.
module tb_bist_sig_compactor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        capture_en;
  logic        finish;
  logic [2:0]  e_in;
`ifdef BIST_SIG_XMASK_EN
  logic [2:0]  e_mask;
`endif

  logic [7:0]  hf, hf9, hf0, hfs;
  logic [15:0] cycles, cycles9, cycles0;
  logic [1:0]  cycless;
  logic        busy, busy9, busy0, busys;
  logic        sig_valid, sig_valid9, sig_valid0, sig_valids;
  logic        pass_fail, pass_fail9, pass_fail0, pass_fails;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] gold_seq [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hE2};

  always #5 clk = ~clk;

  bist_sig_compactor u_dut (
    .CLK(clk), .RST(rst_n), .start(start), .capture_en(capture_en), .finish(finish), .e_in(e_in),
`ifdef BIST_SIG_XMASK_EN
    .e_mask(e_mask),
`endif
    .hf(hf), .cycles(cycles), .busy(busy), .sig_valid(sig_valid), .pass_fail(pass_fail)
  );

  bist_sig_compactor #(.GOLDEN(8'hFF), .EXP_CYCLES(9)) u_cnt9 (
    .CLK(clk), .RST(rst_n), .start(start), .capture_en(capture_en), .finish(finish), .e_in(e_in),
`ifdef BIST_SIG_XMASK_EN
    .e_mask(e_mask),
`endif
    .hf(hf9), .cycles(cycles9), .busy(busy9), .sig_valid(sig_valid9), .pass_fail(pass_fail9)
  );

  bist_sig_compactor #(.GOLDEN(8'hFF), .EXP_CYCLES(0)) u_cnt0 (
    .CLK(clk), .RST(rst_n), .start(start), .capture_en(capture_en), .finish(finish), .e_in(e_in),
`ifdef BIST_SIG_XMASK_EN
    .e_mask(e_mask),
`endif
    .hf(hf0), .cycles(cycles0), .busy(busy0), .sig_valid(sig_valid0), .pass_fail(pass_fail0)
  );

  bist_sig_compactor #(.CW(2)) u_sat (
    .CLK(clk), .RST(rst_n), .start(start), .capture_en(capture_en), .finish(finish), .e_in(e_in),
`ifdef BIST_SIG_XMASK_EN
    .e_mask(e_mask),
`endif
    .hf(hfs), .cycles(cycless), .busy(busys), .sig_valid(sig_valids), .pass_fail(pass_fails)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [2:0] v, input bit fin);
    capture_en = 1'b1;
    e_in       = v;
    finish     = fin;
    tick();
    capture_en = 1'b0;
    e_in       = 3'b000;
    finish     = 1'b0;
  endtask

  task automatic gap();
    capture_en = 1'b0;
    e_in       = 3'b111;
    tick();
    e_in       = 3'b000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; capture_en = 1'b0; finish = 1'b0; e_in = 3'b000;
`ifdef BIST_SIG_XMASK_EN
    e_mask = 3'b000;
`endif
    tick();
    tick();

    // idle: capture without start does nothing
    rst_n = 1'b1; capture_en = 1'b1; e_in = 3'b111;
    tick();
    chk("idle_hf", 32'(hf), 32'h00);
    chk("idle_cycles", 32'(cycles), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sig_valid", 32'(sig_valid), 32'd0);
    chk("idle_pass_fail", 32'(pass_fail), 32'd0);

    // golden pass with per-word signature check
    capture_en = 1'b0; e_in = 3'b000;
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hf", 32'(hf), 32'h00);
    for (int i = 0; i < 9; i++) begin
      word(3'b001, i == 8);
      chk($sformatf("gold_hf_%0d", i), 32'(hf), 32'(gold_seq[i]));
    end
    chk("gold_cycles", 32'(cycles), 32'd9);
    chk("compare_busy", 32'(busy), 32'd1);
    chk("compare_sig_valid", 32'(sig_valid), 32'd0);
    capture_en = 1'b1; e_in = 3'b111;
    tick();
    chk("done_hf_no_compact", 32'(hf), 32'hE2);
    chk("done_sig_valid", 32'(sig_valid), 32'd1);
    chk("done_pass_fail", 32'(pass_fail), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0; capture_en = 1'b0; e_in = 3'b000;
    chk("done_hold_hf", 32'(hf), 32'hE2);
    chk("done_hold_pf", 32'(pass_fail), 32'd1);
    chk("done_hold_cycles", 32'(cycles), 32'd9);

    // restart from DONE, then a faulty response on word 4
    pulse_start();
    chk("restart_sig_valid", 32'(sig_valid), 32'd0);
    chk("restart_pass_fail", 32'(pass_fail), 32'd0);
    chk("restart_hf", 32'(hf), 32'h00);
    chk("restart_cycles", 32'(cycles), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) word((i == 3) ? 3'b011 : 3'b001, i == 8);
    chk("fault_hf", 32'(hf), 32'hA2);
    tick();
    chk("fault_sig_valid", 32'(sig_valid), 32'd1);
    chk("fault_pass_fail", 32'(pass_fail), 32'd0);

    // eight words only: count check and counter saturation
    pulse_start();
    for (int i = 0; i < 8; i++) word(3'b001, i == 7);
    chk("short_hf", 32'(hf), 32'hFF);
    chk("short_cycles", 32'(cycles), 32'd8);
    chk("sat_cycles", 32'(cycless), 32'd3);
    tick();
    chk("short_pf_default", 32'(pass_fail), 32'd0);
    chk("short_pf_exp9", 32'(pass_fail9), 32'd0);
    chk("short_pf_exp0", 32'(pass_fail0), 32'd1);
    chk("short_sv_exp0", 32'(sig_valid0), 32'd1);

    // gated capture with a stray start inside COMPACT
    pulse_start();
    for (int i = 0; i < 18; i++) begin
      if (i % 2 == 1) begin
        word(3'b001, i == 17);
      end else begin
        start = (i == 6);
        gap();
        start = 1'b0;
      end
    end
    chk("gated_hf", 32'(hf), 32'hE2);
    chk("gated_cycles", 32'(cycles), 32'd9);
    tick();
    chk("gated_pass_fail", 32'(pass_fail), 32'd1);

    // reset in the middle of a session
    pulse_start();
    for (int i = 0; i < 5; i++) word(3'b001, 1'b0);
    chk("mid_hf", 32'(hf), 32'h1F);
    rst_n = 1'b0; capture_en = 1'b1; e_in = 3'b111;
    tick();
    chk("rst_hf", 32'(hf), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_idle_hf", 32'(hf), 32'h00);
    chk("rst_idle_busy", 32'(busy), 32'd0);

    // start and finish together in IDLE: start wins
    capture_en = 1'b0; e_in = 3'b000;
    start = 1'b1; finish = 1'b1;
    tick();
    start = 1'b0; finish = 1'b0;
    tick();
    chk("sf_busy", 32'(busy), 32'd1);
    chk("sf_sig_valid", 32'(sig_valid), 32'd0);
    for (int i = 0; i < 9; i++) word(3'b001, i == 8);
    tick();
    chk("post_rst_hf", 32'(hf), 32'hE2);
    chk("post_rst_pass_fail", 32'(pass_fail), 32'd1);

`ifdef BIST_SIG_XMASK_EN
    // masked fault bit restores the golden signature
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      e_mask = (i == 3) ? 3'b010 : 3'b000;
      word((i == 3) ? 3'b011 : 3'b001, i == 8);
    end
    e_mask = 3'b000;
    tick();
    chk("mask_hf", 32'(hf), 32'hE2);
    chk("mask_pass_fail", 32'(pass_fail), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
